// File: rtl/ascon_fsm_pkg.sv
// Shared types and constants for the Ascon control FSM.
// Phase encoding plus round-count constants.
package ascon_pack;

    localparam int ROUNDS_A   = 12;
    localparam int ROUNDS_B   = 6;
    localparam int RC_START_B = ROUNDS_A - ROUNDS_B;
    localparam int RC_LAST    = ROUNDS_A - 1;
    localparam int RC_W       = 4;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        AD_WAIT,
        AD,
        PT_WAIT,
        PT,
        FINAL,
        END
    } type_fsm;

    function automatic logic is_round_state(type_fsm s);
        return (s == INIT) || (s == AD) || (s == PT) || (s == FINAL);
    endfunction

endpackage

// File: rtl/ascon_fsm_if.sv
// Control bundle between the Ascon FSM and its datapath/host.
// master drives start/data_valid, slave (the FSM) drives controls.
interface ascon_fsm_if;
    import ascon_pack::*;

    logic            start;
    logic            data_valid;
    logic [RC_W-1:0] round;
    logic            en_reg_state;
    logic            init_state;
    logic            bypass_xor_begin;
    logic            key_xor_begin;
    logic            bypass_xor_end;
    logic            mode_xor_key;
    logic            data_ready;
    logic            cipher_valid;
    logic            tag_valid;
    logic            busy;

    modport master (
        output start, data_valid,
        input  round, en_reg_state, init_state, bypass_xor_begin,
        input  key_xor_begin, bypass_xor_end, mode_xor_key,
        input  data_ready, cipher_valid, tag_valid, busy
    );

    modport slave (
        input  start, data_valid,
        output round, en_reg_state, init_state, bypass_xor_begin,
        output key_xor_begin, bypass_xor_end, mode_xor_key,
        output data_ready, cipher_valid, tag_valid, busy
    );

endinterface

// File: rtl/ascon_fsm_round_counter.sv
// Permutation round index: loads 0 or 6, counts up,
// saturates at the last round.
module ascon_round_counter
    import ascon_pack::*;
(
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic            load_b_i,
    input  logic            inc_i,
    output logic [RC_W-1:0] round_o,
    output logic            last_o
);

    logic [RC_W-1:0] r_cnt;

    // Load wins over increment; never count past the last round
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_b_i ? RC_W'(RC_START_B) : '0;
        end else if (inc_i && !last_o) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign round_o = r_cnt;
    assign last_o  = (r_cnt == RC_W'(RC_LAST));

endmodule

// File: rtl/ascon_fsm.sv
// Ascon encryption sequencer: INIT, AD, PT blocks, FINAL, tag.
// Outputs are decoded from state, round and block counters.
module ascon_fsm
    import ascon_pack::*;
#(
    parameter int NB_PT_BLOCKS = 4
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            data_valid_i,
    output logic [RC_W-1:0] round_o,
    output logic            en_reg_state_o,
    output logic            init_state_o,
    output logic            bypass_xor_begin_o,
    output logic            key_xor_begin_o,
    output logic            bypass_xor_end_o,
    output logic            mode_xor_key_o,
    output logic            data_ready_o,
    output logic            cipher_valid_o,
    output logic            tag_valid_o,
    output logic            busy_o
);

    localparam logic [3:0] LAST_BLK = 4'(NB_PT_BLOCKS - 1);

    type_fsm         r_state;
    type_fsm         w_next;
    logic [3:0]      r_blk;
    logic            w_blk_inc;
    logic            w_blk_clr;
    logic            w_load;
    logic            w_load_b;
    logic            w_inc;
    logic            w_last;
    logic [RC_W-1:0] w_round;
    logic            w_r0;
    logic            w_rb;

    ascon_round_counter u_rc (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .load_i   (w_load),
        .load_b_i (w_load_b),
        .inc_i    (w_inc),
        .round_o  (w_round),
        .last_o   (w_last)
    );

    // State register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Plaintext block counter, cleared when a message starts
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_blk <= '0;
        end else if (w_blk_clr) begin
            r_blk <= '0;
        end else if (w_blk_inc) begin
            r_blk <= r_blk + 1'b1;
        end
    end

    // Next state and round-counter control
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_load_b  = 1'b0;
        w_inc     = 1'b0;
        w_blk_inc = 1'b0;
        w_blk_clr = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next    = INIT;
                    w_load    = 1'b1;
                    w_blk_clr = 1'b1;
                end
            end
            INIT: begin
                if (w_last) w_next = AD_WAIT;
                else        w_inc  = 1'b1;
            end
            AD_WAIT: begin
                if (data_valid_i) begin
                    w_next   = AD;
                    w_load   = 1'b1;
                    w_load_b = 1'b1;
                end
            end
            AD: begin
                if (w_last) w_next = PT_WAIT;
                else        w_inc  = 1'b1;
            end
            PT_WAIT: begin
                if (data_valid_i) begin
                    w_load = 1'b1;
                    if (r_blk == LAST_BLK) begin
                        w_next = FINAL;
                    end else begin
                        w_next   = PT;
                        w_load_b = 1'b1;
                    end
                end
            end
            PT: begin
                if (w_last) begin
                    w_next    = PT_WAIT;
                    w_blk_inc = 1'b1;
                end else begin
                    w_inc = 1'b1;
                end
            end
            FINAL: begin
                if (w_last) w_next = END;
                else        w_inc  = 1'b1;
            end
            END: begin
                w_next = IDLE;
                w_load = 1'b1;
            end
        endcase
    end

    assign w_r0 = (w_round == '0);
    assign w_rb = (w_round == RC_W'(RC_START_B));

    // Moore output decode
    always_comb begin
        round_o            = w_round;
        en_reg_state_o     = is_round_state(r_state);
        init_state_o       = (r_state == INIT) && w_r0;
        key_xor_begin_o    = (r_state == FINAL) && w_r0;
        data_ready_o       = ((r_state == AD) && w_rb)
                           || ((r_state == PT) && w_rb)
                           || key_xor_begin_o;
        cipher_valid_o     = ((r_state == PT) && w_rb)
                           || key_xor_begin_o;
        bypass_xor_begin_o = !data_ready_o;
        mode_xor_key_o     = ((r_state == INIT) || (r_state == FINAL))
                           && w_last;
        bypass_xor_end_o   = !(mode_xor_key_o
                           || ((r_state == AD) && w_last));
        tag_valid_o        = (r_state == END);
        busy_o             = (r_state != IDLE);
    end

endmodule

// File: tb/tb_ascon_fsm.sv
// Bench for ascon_fsm: NB=4 and NB=1 instances share stimulus,
// expected outputs come from a cycle timeline of the sequence.
module tb_ascon_fsm;
    import ascon_pack::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ascon_fsm_if u_if4 ();
    ascon_fsm_if u_if1 ();

    ascon_fsm #(.NB_PT_BLOCKS(4)) u_dut4 (
        .clock_i            (clk),
        .reset_i            (rst),
        .start_i            (u_if4.start),
        .data_valid_i       (u_if4.data_valid),
        .round_o            (u_if4.round),
        .en_reg_state_o     (u_if4.en_reg_state),
        .init_state_o       (u_if4.init_state),
        .bypass_xor_begin_o (u_if4.bypass_xor_begin),
        .key_xor_begin_o    (u_if4.key_xor_begin),
        .bypass_xor_end_o   (u_if4.bypass_xor_end),
        .mode_xor_key_o     (u_if4.mode_xor_key),
        .data_ready_o       (u_if4.data_ready),
        .cipher_valid_o     (u_if4.cipher_valid),
        .tag_valid_o        (u_if4.tag_valid),
        .busy_o             (u_if4.busy)
    );

    ascon_fsm #(.NB_PT_BLOCKS(1)) u_dut1 (
        .clock_i            (clk),
        .reset_i            (rst),
        .start_i            (u_if1.start),
        .data_valid_i       (u_if1.data_valid),
        .round_o            (u_if1.round),
        .en_reg_state_o     (u_if1.en_reg_state),
        .init_state_o       (u_if1.init_state),
        .bypass_xor_begin_o (u_if1.bypass_xor_begin),
        .key_xor_begin_o    (u_if1.key_xor_begin),
        .bypass_xor_end_o   (u_if1.bypass_xor_end),
        .mode_xor_key_o     (u_if1.mode_xor_key),
        .data_ready_o       (u_if1.data_ready),
        .cipher_valid_o     (u_if1.cipher_valid),
        .tag_valid_o        (u_if1.tag_valid),
        .busy_o             (u_if1.busy)
    );

    // {round, en, init, byb, keyb, bye, mode, dr, cv, tv, busy}
    logic [13:0] act [2];
    assign act[0] = {u_if4.round, u_if4.en_reg_state, u_if4.init_state,
                     u_if4.bypass_xor_begin, u_if4.key_xor_begin,
                     u_if4.bypass_xor_end, u_if4.mode_xor_key,
                     u_if4.data_ready, u_if4.cipher_valid,
                     u_if4.tag_valid, u_if4.busy};
    assign act[1] = {u_if1.round, u_if1.en_reg_state, u_if1.init_state,
                     u_if1.bypass_xor_begin, u_if1.key_xor_begin,
                     u_if1.bypass_xor_end, u_if1.mode_xor_key,
                     u_if1.data_ready, u_if1.cipher_valid,
                     u_if1.tag_valid, u_if1.busy};

    localparam logic [13:0] IDLE_V = 14'h0A0;

    typedef struct {
        int          dut;
        int          rel;
        logic [13:0] e;
        logic [13:0] m;
    } sb_t;

    typedef struct {
        int adw;
        int spur_a;
        int spur_b;
        int rst_at;
        int len;
        int tag4;
        int tag1;
        int cv4;
        int cv1;
    } vec_t;

    sb_t  sbq[$];
    vec_t tbl[5];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Expected outputs rel cycles after start_i was sampled.
    // adw = number of AD_WAIT cycles (1 when data_valid held high).
    function automatic void tl(input int rel, input int nb, input int adw,
                               output logic [13:0] e, output logic [13:0] m);
        int   ph, r, q, f;
        logic en, ini, byb, kb, bye, md, dr, cv, tv, bs;
        ph = 0; r = 0; m = '1;
        if (rel <= 0) begin
            ph = 0;
        end else if (rel <= 12) begin
            ph = 1; r = rel - 1;
        end else if (rel < 13 + adw) begin
            ph = 2; r = 11;
        end else begin
            q = rel - (adw - 1);
            f = 21 + 7 * (nb - 1);
            if (q <= 19) begin
                ph = 3; r = q - 8;
            end else if (q < f) begin
                if (q == 20 || (q - 21) % 7 == 6) begin
                    ph = 2; r = 11;
                end else begin
                    ph = 4; r = 6 + (q - 21) % 7;
                end
            end else if (q <= f + 11) begin
                ph = 5; r = q - f;
            end else if (q == f + 12) begin
                ph = 6;
            end else begin
                ph = 7;
            end
        end
        if (ph == 6 || ph == 7) m[13:10] = '0;
        en  = (ph == 1) || (ph == 3) || (ph == 4) || (ph == 5);
        ini = (ph == 1) && (r == 0);
        kb  = (ph == 5) && (r == 0);
        dr  = ((ph == 3 || ph == 4) && r == 6) || kb;
        cv  = (ph == 4 && r == 6) || kb;
        byb = !dr;
        md  = (ph == 1 || ph == 5) && (r == 11);
        bye = !(md || (ph == 3 && r == 11));
        tv  = (ph == 6);
        bs  = (ph != 0) && (ph != 7);
        e = {4'(r), en, ini, byb, kb, bye, md, dr, cv, tv, bs};
    endfunction

    task automatic chk(input string nm, input logic [13:0] a,
                       input logic [13:0] e, input logic [13:0] m);
        n_tests++;
        if ((a & m) !== (e & m)) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (mask %h)", nm, a, e, m);
        end
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        n_tests++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic drive(input logic s, input logic d);
        u_if4.start = s; u_if1.start = s;
        u_if4.data_valid = d; u_if1.data_valid = d;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [13:0] e, m;
        sb_t         it;
        int          tg[2];
        int          cvn[2];
        vec_t        v;

        //        adw spa spb rst len tag4 tag1 cv4 cv1
        tbl[0] = '{1, -1, -1, -1, 62, 54, 33, 4, 1};
        tbl[1] = '{6, -1, -1, -1, 62, 59, 38, 4, 1};
        tbl[2] = '{1,  5, 30, -1, 62, 54, 33, 4, 1};
        tbl[3] = '{1, -1, -1,  6,  7, -1, -1, 0, 0};
        tbl[4] = '{1, -1, -1, -1, 62, 54, 33, 4, 1};

        rst = 1'b1;
        drive(1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_nb4", act[0], IDLE_V, '1);
        chk("reset_nb1", act[1], IDLE_V, '1);

        for (int i = 0; i < 5; i++) begin
            v = tbl[i];
            tg = '{-1, -1};
            cvn = '{0, 0};
            for (int rel = 0; rel < v.len; rel++) begin
                drive(rel == 0 || rel == v.spur_a || rel == v.spur_b,
                      (v.adw == 1) || !(rel >= 1 && rel <= 11 + v.adw));
                rst = (rel == v.rst_at);
                for (int d = 0; d < 2; d++) begin
                    tl(rel + 1, d == 0 ? 4 : 1, v.adw, e, m);
                    if (v.rst_at >= 0 && rel + 1 > v.rst_at) begin
                        e = IDLE_V; m = '1;
                    end
                    sbq.push_back('{d, rel + 1, e, m});
                end
                tick();
                while (sbq.size() > 0) begin
                    it = sbq.pop_front();
                    chk($sformatf("s%0d_dut%0d_c%0d", i, it.dut, it.rel),
                        act[it.dut], it.e, it.m);
                    if (act[it.dut][1] && tg[it.dut] < 0) tg[it.dut] = it.rel;
                    if (act[it.dut][2]) cvn[it.dut]++;
                end
            end
            rst = 1'b0;
            drive(1'b0, 1'b1);
            chk_int($sformatf("s%0d_tag_cycle_nb4", i), tg[0], v.tag4);
            chk_int($sformatf("s%0d_tag_cycle_nb1", i), tg[1], v.tag1);
            chk_int($sformatf("s%0d_cipher_cnt_nb4", i), cvn[0], v.cv4);
            chk_int($sformatf("s%0d_cipher_cnt_nb1", i), cvn[1], v.cv1);
            tick();
        end

        // Reset in the middle of an AD phase
        drive(1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b1);
        for (int k = 0; k < 15; k++) tick();
        tl(16, 4, 1, e, m);
        chk("mid_ad_nb4", act[0], e, m);
        tl(16, 1, 1, e, m);
        chk("mid_ad_nb1", act[1], e, m);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ad_reset_nb4", act[0], IDLE_V, '1);
        chk("ad_reset_nb1", act[1], IDLE_V, '1);
        drive(1'b0, 1'b0);
        tick();
        chk("stay_idle_nb4", act[0], IDLE_V, '1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
